// File: rtl/ddr3_wrlvl_pkg.sv
// Shared types and constants for the DDR3 DQSW lane write-leveling sequencer.
package ddr3_wrlvl_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StLoadWait,
    StPulse,
    StSettle,
    StSample,
    StDecide,
    StMove,
    StMoveWait,
    StDone,
    StErr
  } wrlvl_state_e;

  localparam logic DIR_INC = 1'b1;

  // Majority needs strictly more ones than this; a tie reads as 0.
  function automatic int unsigned vote_threshold(input int unsigned num_samples);
    return num_samples / 2;
  endfunction

endpackage

// File: rtl/wrlvl_sample_vote.sv
// Accumulates NUM_SAMPLES feedback bits and majority-votes them.
module wrlvl_sample_vote
  import ddr3_wrlvl_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic level_o,
  output logic valid_o
);

  localparam int unsigned CntW = $clog2(NUM_SAMPLES) + 1;
  localparam logic [CntW-1:0] Full   = CntW'(NUM_SAMPLES);
  localparam logic [CntW-1:0] Thresh = CntW'(vote_threshold(NUM_SAMPLES));

  logic [CntW-1:0] ones_q, ones_d;
  logic [CntW-1:0] sample_cnt_q, sample_cnt_d;
  logic            full;

  assign full = (sample_cnt_q == Full);

  // Counting stops once full, so neither counter can wrap.
  always_comb begin
    ones_d       = ones_q;
    sample_cnt_d = sample_cnt_q;
    if (clr_i) begin
      ones_d       = '0;
      sample_cnt_d = '0;
    end else if (en_i && !full) begin
      ones_d       = ones_q + {{(CntW-1){1'b0}}, bit_i};
      sample_cnt_d = sample_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ones_q       <= '0;
      sample_cnt_q <= '0;
    end else begin
      ones_q       <= ones_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign valid_o = full;
  assign level_o = (ones_q > Thresh);

endmodule

// File: rtl/ddr3_dqsw_lane_wrlvl_ctrl.sv
// Write-leveling sequencer: sweeps the DQSW delay line up one tap at a time and stops at the
// first voted 0->1 transition of the DQ feedback.
module ddr3_dqsw_lane_wrlvl_ctrl
  import ddr3_wrlvl_pkg::*;
#(
  parameter int unsigned MAX_TAPS      = 128,
  parameter int unsigned TAP_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned NUM_SAMPLES   = 8,
  parameter int unsigned MOVE_WAIT     = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             DQS_PULSE_REQ,
  input  logic             DQS_PULSE_ACK,
  input  logic [1:0]       RX_DATA,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  output logic [TAP_W-1:0] TAP_COUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR
);

  localparam int unsigned WaitMax0 = (SETTLE_CYCLES > MOVE_WAIT) ? SETTLE_CYCLES : MOVE_WAIT;
  localparam int unsigned WaitMax  = (WaitMax0 > NUM_SAMPLES) ? WaitMax0 : NUM_SAMPLES;
  localparam int unsigned CntW     = $clog2(WaitMax + 1);

  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]  SampleLast = CntW'(NUM_SAMPLES - 1);
  localparam logic [CntW-1:0]  MoveLast   = CntW'(MOVE_WAIT - 1);
  localparam logic [TAP_W-1:0] TapLast    = TAP_W'(MAX_TAPS - 1);

  wrlvl_state_e     state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [TAP_W-1:0] tap_q;
  logic             seen_zero_q;
  logic             start_ok;
  logic             counting;
  logic             vote_level, vote_valid, level_one;
  logic             unused_rx;

  assign unused_rx = RX_DATA[1];
  assign start_ok  = START && (state_q inside {StIdle, StDone, StErr});
  assign counting  = state_q inside {StLoadWait, StSettle, StSample, StMoveWait};
  assign level_one = vote_valid && vote_level;

  wrlvl_sample_vote #(
    .NUM_SAMPLES(NUM_SAMPLES)
  ) u_vote (
    .clk_i  (FAB_CLK),
    .rst_i  (RESET),
    .clr_i  (state_q == StSettle),
    .en_i   (state_q == StSample),
    .bit_i  (RX_DATA[0]),
    .level_o(vote_level),
    .valid_o(vote_valid)
  );

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (START) state_d = StLoad;
      StLoad:                state_d = StLoadWait;
      StLoadWait:            if (cnt_q == MoveLast) state_d = StPulse;
      StPulse:               if (DQS_PULSE_ACK) state_d = StSettle;
      StSettle:              if (cnt_q == SettleLast) state_d = StSample;
      StSample:              if (cnt_q == SampleLast) state_d = StDecide;
      StDecide: begin
        if (level_one && seen_zero_q) state_d = StDone;
        else if (tap_q == TapLast)    state_d = StErr;
        else                          state_d = StMove;
      end
      StMove:                state_d = StMoveWait;
      StMoveWait: begin
        if (DELAY_LINE_OUT_OF_RANGE) state_d = StErr;
        else if (cnt_q == MoveLast)  state_d = StPulse;
      end
      default:               state_d = StIdle;
    endcase
  end

  // Wait counter restarts on every state change and only runs in timed states.
  always_comb begin
    cnt_d = '0;
    if (counting && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q       <= '0;
      tap_q       <= '0;
      seen_zero_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (start_ok) begin
        tap_q       <= '0;
        seen_zero_q <= 1'b0;
      end else if (state_q == StMove) begin
        tap_q <= tap_q + 1'b1;
      end else if ((state_q == StDecide) && !level_one) begin
        seen_zero_q <= 1'b1;
      end
    end
  end

  always_comb begin
    DQS_PULSE_REQ        = 1'b0;
    DELAY_LINE_MOVE      = 1'b0;
    DELAY_LINE_LOAD      = 1'b0;
    DELAY_LINE_DIRECTION = 1'b0;
    BUSY                 = 1'b0;
    DONE                 = 1'b0;
    ERROR                = 1'b0;
    TAP_COUNT            = tap_q;
    unique case (state_q)
      StIdle:  ;
      StDone:  DONE  = 1'b1;
      StErr:   ERROR = 1'b1;
      default: begin
        BUSY                 = 1'b1;
        DELAY_LINE_DIRECTION = DIR_INC;
        DQS_PULSE_REQ        = (state_q == StPulse);
        DELAY_LINE_MOVE      = (state_q == StMove);
        DELAY_LINE_LOAD      = (state_q == StLoad);
      end
    endcase
  end

endmodule

// File: tb/tb_ddr3_dqsw_lane_wrlvl_ctrl.sv
// Directed bench for the write-leveling sequencer with a scoreboard of per-run results.
module tb_ddr3_dqsw_lane_wrlvl_ctrl;

  localparam int unsigned MaxTaps = 16;

  logic       FAB_CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic       ACK = 1'b0;
  logic       OOR = 1'b0;
  logic [1:0] RX = 2'b00;
  logic       REQ, MOVE, DIR, LOAD, BUSY, DONE, ERROR;
  logic [7:0] TAP;

  ddr3_dqsw_lane_wrlvl_ctrl #(
    .MAX_TAPS     (MaxTaps),
    .TAP_W        (8),
    .SETTLE_CYCLES(16),
    .NUM_SAMPLES  (8),
    .MOVE_WAIT    (4)
  ) dut (
    .FAB_CLK                (FAB_CLK),
    .RESET                  (RESET),
    .START                  (START),
    .DQS_PULSE_REQ          (REQ),
    .DQS_PULSE_ACK          (ACK),
    .RX_DATA                (RX),
    .DELAY_LINE_OUT_OF_RANGE(OOR),
    .DELAY_LINE_MOVE        (MOVE),
    .DELAY_LINE_DIRECTION   (DIR),
    .DELAY_LINE_LOAD        (LOAD),
    .TAP_COUNT              (TAP),
    .BUSY                   (BUSY),
    .DONE                   (DONE),
    .ERROR                  (ERROR)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    int done;
    int error;
    int tap;
    int moves;
    int loads;
    int reqs;
  } exp_t;

  exp_t exp_q[$];

  int         n_tests = 0;
  int         n_fail = 0;
  int         ack_delay = 0;
  int         oor_at = 0;
  int         bench_tap = 0;
  int         n_moves = 0;
  int         n_loads = 0;
  int         n_reqs = 0;
  logic       req_prev = 1'b0;
  logic       mon_prev = 1'b0;
  logic [7:0] pat [16];
  logic [7:0] cur;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_result(input int d, input int e, input int t, input int m,
                               input int l, input int r);
    exp_t x;
    x.done = d; x.error = e; x.tap = t; x.moves = m; x.loads = l; x.reqs = r;
    exp_q.push_back(x);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_strobes"}, {REQ, MOVE, DIR, LOAD, BUSY, DONE, ERROR}, 0);
    check({tag, "_tap"}, TAP, 0);
  endtask

  // Caller sits #1 after a rising edge.
  task automatic start_run(input int ack, input int oor);
    ack_delay = ack;
    oor_at    = oor;
    n_moves   = 0;
    n_loads   = 0;
    n_reqs    = 0;
    START = 1'b1;
    @(posedge FAB_CLK); #1;
    START = 1'b0;
    check("load_pulse", LOAD, 1);
    check("dir_inc", DIR, 1);
    check("busy_on_start", BUSY, 1);
    check("tap_cleared", TAP, 0);
    check("flags_cleared", {DONE, ERROR}, 0);
  endtask

  task automatic wait_end(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge FAB_CLK);
      if (DONE || ERROR) got = 1'b1;
    end
    check({tag, "_finished"}, got, 1);
    repeat (3) @(posedge FAB_CLK);
    #1;
  endtask

  // IOD/DRAM side bookkeeping: tap tracking, strobe counting, out-of-range injection.
  initial forever begin
    @(negedge FAB_CLK);
    if (RESET) begin
      bench_tap = 0;
    end else begin
      if (LOAD) begin
        bench_tap = 0;
        n_loads++;
      end
      if (MOVE) begin
        bench_tap++;
        n_moves++;
        if (oor_at != 0 && n_moves == oor_at) OOR = 1'b1;
      end
    end
    if (REQ && !req_prev) n_reqs++;
    req_prev = REQ;
    if (DONE || ERROR) OOR = 1'b0;
  end

  // DQS pulse responder: ack after ack_delay cycles, then present the tap's sample pattern.
  initial forever begin
    @(posedge FAB_CLK); #1;
    if (REQ && !RESET) begin
      for (int j = 0; j < ack_delay; j++) begin
        @(posedge FAB_CLK); #1;
      end
      ACK = 1'b1;
      @(posedge FAB_CLK); #1;
      ACK = 1'b0;
      cur = pat[bench_tap];
      repeat (16) @(posedge FAB_CLK);
      #1;
      for (int i = 0; i < 8; i++) begin
        RX[0] = cur[i];
        @(posedge FAB_CLK); #1;
      end
      RX[0] = 1'b0;
    end
  end

  // Monitor: on each completion pop the expected result and compare.
  initial forever begin
    @(negedge FAB_CLK);
    if ((DONE || ERROR) && !mon_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done", DONE, e.done);
        check("error", ERROR, e.error);
        check("tap_count", TAP, e.tap);
        check("move_pulses", n_moves, e.moves);
        check("load_pulses", n_loads, e.loads);
        check("dqs_requests", n_reqs, e.reqs);
        check("flags_exclusive", DONE & ERROR, 0);
        check("busy_at_end", BUSY, 0);
      end
    end
    mon_prev = DONE || ERROR;
  end

  initial begin
    bit hit;
    RESET = 1'b1;
    repeat (3) @(posedge FAB_CLK);
    #1;
    check_quiet("reset");
    RESET = 1'b0;
    @(posedge FAB_CLK); #1;

    // Edge at tap 5, ack two cycles after request.
    for (int i = 0; i < 16; i++) pat[i] = (i >= 5) ? 8'hFF : 8'h00;
    expect_result(1, 0, 5, 5, 1, 6);
    start_run(2, 0);
    wait_end("edge5");

    // Start inside the high region: taps 0-2 high must not finish training.
    for (int i = 0; i < 16; i++) pat[i] = (i <= 2 || i >= 10) ? 8'hFF : 8'h00;
    expect_result(1, 0, 10, 10, 1, 11);
    start_run(0, 0);
    wait_end("high_start");

    // No edge: sweep runs out at MAX_TAPS-1.
    for (int i = 0; i < 16; i++) pat[i] = 8'h00;
    expect_result(0, 1, 15, 15, 1, 16);
    start_run(1, 0);
    wait_end("no_edge");

    // Out-of-range after the third move.
    expect_result(0, 1, 3, 3, 1, 3);
    start_run(3, 3);
    wait_end("out_of_range");

    // Vote threshold: 4 ones at tap 1 reads 0, 5 ones at tap 2 reads 1.
    for (int i = 0; i < 16; i++) pat[i] = 8'hFF;
    pat[0] = 8'h00;
    pat[1] = 8'b0101_0101;
    pat[2] = 8'b1011_0101;
    expect_result(1, 0, 2, 2, 1, 3);
    start_run(1, 0);
    wait_end("vote");

    // Reset during SETTLE at tap 7.
    for (int i = 0; i < 16; i++) pat[i] = 8'h00;
    start_run(1, 0);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge FAB_CLK);
      if (bench_tap == 7) hit = 1'b1;
    end
    check("reach_tap7", hit, 1);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge FAB_CLK);
      if (REQ) hit = 1'b1;
    end
    check("req_at_tap7", hit, 1);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge FAB_CLK);
      if (!REQ) hit = 1'b1;
    end
    check("settle_at_tap7", hit, 1);
    @(posedge FAB_CLK); #3;
    RESET = 1'b1;
    #1;
    check_quiet("mid_sweep_reset");
    n_moves = 0;
    repeat (5) @(posedge FAB_CLK);
    #1;
    check("moves_during_reset", n_moves, 0);
    RESET = 1'b0;
    repeat (40) @(posedge FAB_CLK);
    #1;
    check_quiet("after_reset");

    // Fresh run after reset, with a START pulsed while busy.
    for (int i = 0; i < 16; i++) pat[i] = (i >= 3) ? 8'hFF : 8'h00;
    expect_result(1, 0, 3, 3, 1, 4);
    start_run(0, 0);
    START = 1'b1;
    @(posedge FAB_CLK); #1;
    START = 1'b0;
    check("busy_start_no_load", LOAD, 0);
    wait_end("restart");

    repeat (5) @(posedge FAB_CLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
